// File: rtl/echo_assertion_bank_if.sv
// Bus bundle for echo_assertion_bank: per-channel trigger/latency/flush requests in,
// stretched assertions and natural-end pulses out.
interface echo_assertion_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
);
    logic [CHANNELS-1:0]       trigger;
    logic [CHANNELS*CNT_W-1:0] latency;
    logic [CHANNELS-1:0]       flush;
    logic                      hold;
    logic [CHANNELS-1:0]       assertion;
    logic [CHANNELS-1:0]       expire;
    logic                      any_asserted;

    modport master (
        output trigger, latency, flush, hold,
        input  assertion, expire, any_asserted
    );

    modport slave (
        input  trigger, latency, flush, hold,
        output assertion, expire, any_asserted
    );
endinterface

// File: rtl/echo_assertion_bank.sv
// Bank of independent echo channels: a trigger stretches into an assertion lasting
// 'latency' cycles, with per-channel flush, a shared hold and a natural-end pulse.
module echo_assertion_bank #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 4,
    parameter int IMMEDIATE = 1,
    parameter int MODE      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    echo_assertion_bank_if.slave  bus
);
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            expire_q, expire_d;
    logic [CHANNELS-1:0]            busy;
    logic [CHANNELS-1:0]            assertion;

    always_comb begin
        cnt_d    = cnt_q;
        expire_d = '0;
        busy     = '0;
        for (int i = 0; i < CHANNELS; i++) begin : g_ch
            logic [CNT_W-1:0] lat;
            logic [CNT_W-1:0] dec;
            logic [CNT_W-1:0] keep;
            logic             accept;
            lat     = bus.latency[i*CNT_W +: CNT_W];
            busy[i] = (cnt_q[i] != '0);
            dec     = busy[i] ? cnt_q[i] - CNT_W'(1) : '0;
            keep    = bus.hold ? cnt_q[i] : dec;
            // In ignore-while-busy mode a trigger on a running channel is simply dropped.
            accept  = bus.trigger[i] && ((MODE != 1) || !busy[i]);
            if (bus.flush[i]) begin
                cnt_d[i] = '0;
            end else if (accept) begin
                if (MODE == 2) begin
                    cnt_d[i] = (lat > keep) ? lat : keep;
                end else begin
                    cnt_d[i] = lat;
                end
            end else if (!bus.hold) begin
                cnt_d[i]    = dec;
                expire_d[i] = (cnt_q[i] == CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            expire_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    // The immediate path is combinational so the trigger cycle itself can assert.
    assign assertion        = ((IMMEDIATE != 0) ? (bus.trigger & ~bus.flush) : '0) | busy;
    assign bus.assertion    = assertion;
    assign bus.expire       = expire_q;
    assign bus.any_asserted = |assertion;
endmodule
